friscv_dmem_arbiter: RTL and testbench
======================================

Name: friscv_dmem_arbiter

Overview:
- Arbitrates the single-port synchronous data memory between two requesters. Requester 0 is the pipelined core's load/store port; requester 1 is the debug/program loader port.
- Sits inside friscv_fpga_wrapper, between those two masters and the dmem BRAM.
- Handles one transaction at a time, with round-robin priority and valid/ready handshakes on both the request and the response channels.

Parameters:
- ADDR_WIDTH, 10, word address width to dmem.
- DATA_WIDTH, 32, data width. Must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8 is derived internally.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  request valid (N = 0, 1; the same set of ports exists for each requester).
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_be  in  BE_WIDTH  byte enables for the write.
- rspN_valid  out  1  response valid.
- rspN_ready  in  1  response consumed.
- rspN_rdata  out  DATA_WIDTH  read data; 0 for writes.
- mem_en  out  1  BRAM enable.
- mem_we  out  BE_WIDTH  BRAM byte write enables.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_wdata  out  DATA_WIDTH  BRAM write data.
- mem_rdata  in  DATA_WIDTH  BRAM read data, valid one cycle after mem_en.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  requester currently owning the transaction.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0: reqN_ready, rspN_valid, rspN_rdata, mem_*, busy, grant_id.
  - An in-flight transaction is discarded with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner selection: if only one reqN_valid is high, that requester wins. If both are high, the winner is the requester != last_grant.
  - reqW_ready = 1 combinationally for the winner only. The loser's ready stays 0.
  - In the accept cycle, latch we/addr/wdata/be, set grant_id = W and last_grant = W, then go to ISSUE.
  - No valid input: stay in IDLE, all readies 0.
- ISSUE (one cycle):
  - Drive mem_en = 1, mem_addr, mem_wdata.
  - mem_we = latched be if we = 1, else 0.
  - Go to WAIT.
- WAIT (one cycle):
  - mem_en = 0.
  - Capture mem_rdata into the response register for a read, or 0 for a write.
  - Go to RESP.
- RESP:
  - rspG_valid = 1, with G = grant_id. rspG_rdata is held stable.
  - The other requester's rsp_valid stays 0.
  - On rspG_ready = 1, drop valid and go to IDLE. Otherwise hold.
- Latency and throughput:
  - Accept at cycle N; mem_en at N+1; rsp_valid at N+3.
  - With rsp_ready tied high, the next accept is possible at N+4, i.e. 4 cycles per transaction.
- reqN_ready is 0 in every state except IDLE. A requester that drops valid before being granted causes no side effects.
- A write with be = 0 still performs an access (mem_en = 1, mem_we = 0). Memory is unchanged and a response is still produced.
- A requester holding valid while the other is served wins the next arbitration. This guarantees no starvation.
- A simultaneous new request and rsp_ready in RESP: the request is accepted no earlier than the following IDLE cycle.
- Outputs are registered, except reqN_ready, which is combinational from the state and reqN_valid.

Test Plan:
- Reset: hold rst_n = 0 with both valids high → all readies, rsp_valids and mem_en are 0. Release → req0_ready = 1 in the first IDLE cycle.
- Single read: preload word 0x005 with 0xDEADBEEF; req0 read addr 0x005 accepted at cycle N → mem_en = 1 at N+1, rsp0_valid = 1 with rdata 0xDEADBEEF at N+3, and rsp1_valid stays 0.
- Byte write: req1 write addr 0x010, wdata 0x11223344, be 0b0011 over existing 0xAABBCCDD → mem_we = 0b0011. A subsequent read of 0x010 returns 0xAABB3344; the write response rdata = 0.
- Round-robin: both valids held high for 4 transactions → grant order 0, 1, 0, 1, and each requester gets exactly 2 responses.
- Response backpressure: rsp0_ready held low for 5 cycles → rsp0_valid and rdata are stable and busy = 1. A pending req1 is not accepted until one cycle after rsp0_ready rises.
- Mid-op reset: assert rst_n = 0 asynchronously in WAIT → outputs go to 0 immediately with no response. After release, both requesting → requester 0 granted first.

Source files
------------

// File: rtl/friscv_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// friscv_dmem_arbiter
//   Shares the single-port synchronous dmem BRAM between two requesters:
//   requester 0 (core load/store port) and requester 1 (debug/program loader).
//   One transaction is in flight at a time; ties are broken round-robin.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake (N = 0, 1)
//   reqN_we/addr/wdata/be      request payload (word address, byte enables)
//   rspN_valid/ready/rdata     response handshake and read data (0 for writes)
//   mem_en/we/addr/wdata       BRAM command (registered)
//   mem_rdata                  BRAM read data, valid one cycle after mem_en
//   busy                       high while a transaction is in progress
//   grant_id                   requester owning the current/last transaction
// ----------------------------------------------------------------------------
module friscv_dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_we,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_be,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_we,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_be,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    busy,
    output logic                    grant_id
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic                  last_grant;
    logic                  lat_we;

    logic                  win_vld;
    logic                  win_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;

    // Winner: the lone requester, or on a tie the one not served last.
    always_comb begin
        win_vld = req0_valid | req1_valid;
        win_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_we    = win_id ? req1_we    : req0_we;
        sel_addr  = win_id ? req1_addr  : req0_addr;
        sel_wdata = win_id ? req1_wdata : req0_wdata;
        sel_be    = win_id ? req1_be    : req0_be;
    end

    // Ready is the only combinational output; rst_n gating keeps it low while
    // reset is held even though the state already reads IDLE.
    assign req0_ready = rst_n && (state == IDLE) && win_vld && !win_id;
    assign req1_ready = rst_n && (state == IDLE) && win_vld &&  win_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        // Command registers are loaded at accept so the BRAM
                        // sees them exactly during ISSUE.
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        lat_we     <= sel_we;
                        mem_en     <= 1'b1;
                        mem_we     <= sel_we ? sel_be : '0;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    mem_en <= 1'b0;
                    mem_we <= '0;
                end
                WAIT: begin
                    // BRAM output is valid now, one cycle after mem_en.
                    state <= RESP;
                    if (grant_id) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= lat_we ? '0 : mem_rdata;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= lat_we ? '0 : mem_rdata;
                    end
                end
                RESP: begin
                    if (grant_id ? rsp1_ready : rsp0_ready) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_friscv_dmem_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model (shadow memory + accept cycle + fixed latency offsets) predicts every
//   output on every cycle; literal expectations pin the model on known cases.
// ----------------------------------------------------------------------------
module tb_friscv_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic [BW-1:0] req0_be = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic [BW-1:0] req1_be = '0;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;

    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_en, busy, grant_id;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    friscv_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    // BRAM: read-first, garbage on the output when not enabled.
    logic [DW-1:0] bram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < BW; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= bram[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // ---------------- model state ----------------
    logic [DW-1:0] shadow [0:1023];
    bit            in_txn;
    bit            lg;
    int            start, owner, gid;
    logic [DW-1:0] exp_rdata, exp_wdata;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_we;
    int            mg_q[$];

    typedef struct { int id; logic [DW-1:0] d; int cyc; } ev_t;
    ev_t acc_q[$], rsp_q[$], en_q[$];

    int cyc = 0, checks = 0, errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int win(logic v0, logic v1, bit l);
        if (v0 && v1) return l ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_accept(int w);
        logic          we;
        logic [BW-1:0] be;
        we        = (w == 0) ? req0_we : req1_we;
        be        = (w == 0) ? req0_be : req1_be;
        exp_addr  = (w == 0) ? req0_addr : req1_addr;
        exp_wdata = (w == 0) ? req0_wdata : req1_wdata;
        exp_we    = we ? be : '0;
        exp_rdata = we ? '0 : shadow[exp_addr];
        for (int b = 0; b < BW; b++)
            if (exp_we[b]) shadow[exp_addr][8*b +: 8] = exp_wdata[8*b +: 8];
        in_txn = 1; start = cyc + 1; owner = w; gid = w; lg = (w == 1);
        mg_q.push_back(w);
    endtask

    // One clock: compare at negedge, advance model, return at posedge+1.
    task automatic step();
        int       w, off;
        logic [1:0] erdy, ervld;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            chk("rst_ready", {req1_ready, req0_ready}, 0);
            chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
            chk("rst_rdata", {rsp1_rdata, rsp0_rdata}, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant_id, 0);
            in_txn = 0; lg = 1; gid = 0;
        end else begin
            if (req0_valid && req0_ready) acc_q.push_back('{0, '0, cyc});
            if (req1_valid && req1_ready) acc_q.push_back('{1, '0, cyc});
            if (rsp0_valid && rsp0_ready) rsp_q.push_back('{0, rsp0_rdata, cyc});
            if (rsp1_valid && rsp1_ready) rsp_q.push_back('{1, rsp1_rdata, cyc});
            if (mem_en) en_q.push_back('{int'(grant_id), DW'(mem_we), cyc});

            w     = in_txn ? -1 : win(req0_valid, req1_valid, lg);
            off   = cyc - start;
            erdy  = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
            ervld = (in_txn && off >= 2) ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("req_ready", {req1_ready, req0_ready}, erdy);
            chk("rsp_valid", {rsp1_valid, rsp0_valid}, ervld);
            chk("busy", busy, in_txn);
            chk("mem_en", mem_en, (in_txn && off == 0));
            chk("grant_id", grant_id, gid);
            if (in_txn && off == 0) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("mem_we", mem_we, exp_we);
            end
            if (ervld[0]) chk("rsp0_rdata", rsp0_rdata, exp_rdata);
            if (ervld[1]) chk("rsp1_rdata", rsp1_rdata, exp_rdata);

            if (w >= 0) model_accept(w);
            else if (in_txn && off >= 2 && ((owner == 0) ? rsp0_ready : rsp1_ready)) in_txn = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(int n, int budget, string nm);
        for (int k = 0; k < budget && acc_q.size() < n; k++) step();
        if (acc_q.size() < n) chk(nm, acc_q.size(), n);
    endtask

    task automatic wait_rsp(int n, int budget, string nm);
        for (int k = 0; k < budget && rsp_q.size() < n; k++) step();
        if (rsp_q.size() < n) chk(nm, rsp_q.size(), n);
    endtask

    initial begin
        int base, na;
        for (int i = 0; i < 1024; i++) begin
            shadow[i] = 32'hA5A50000 ^ (i * 32'h01010101);
            bram[i]  <= 32'hA5A50000 ^ (i * 32'h01010101);
        end
        shadow[5]     = 32'hDEADBEEF;  bram[5]     <= 32'hDEADBEEF;
        shadow[10'h10] = 32'hAABBCCDD; bram[10'h10] <= 32'hAABBCCDD;

        // Reset held with both requesting.
        req0_valid = 1; req0_we = 0; req0_addr = 10'h005;
        req1_valid = 1; req1_we = 1; req1_addr = 10'h010;
        req1_wdata = 32'h11223344; req1_be = 4'b0011;
        repeat (3) step();
        rst_n = 1;
        #1;
        chk("first_idle_req0_ready", req0_ready, 1);
        chk("first_idle_req1_ready", req1_ready, 0);

        // Read 0x005, byte write 0x010, read back 0x010.
        wait_acc(1, 5, "acc_read0_timeout");
        req0_valid = 0;
        wait_acc(2, 10, "acc_write1_timeout");
        req1_we = 0;
        wait_acc(3, 10, "acc_read1_timeout");
        req1_valid = 0;
        wait_rsp(3, 20, "rsp_first3_timeout");
        if (rsp_q.size() >= 3 && acc_q.size() >= 3 && en_q.size() >= 2) begin
            chk("read0_id", rsp_q[0].id, 0);
            chk("read0_data", rsp_q[0].d, 32'hDEADBEEF);
            chk("read0_rsp_latency", rsp_q[0].cyc - acc_q[0].cyc, 3);
            chk("read0_en_latency", en_q[0].cyc - acc_q[0].cyc, 1);
            chk("txn_throughput", acc_q[1].cyc - acc_q[0].cyc, 4);
            chk("write_mem_we", en_q[1].d, 4'b0011);
            chk("write_rsp_id", rsp_q[1].id, 1);
            chk("write_rsp_rdata", rsp_q[1].d, 0);
            chk("readback_data", rsp_q[2].d, 32'hAABB3344);
        end

        // Round-robin with both held.
        base = rsp_q.size();
        na   = mg_q.size();
        req0_valid = 1; req0_we = 0; req0_addr = AW'($urandom_range(0, 15));
        req1_valid = 1; req1_we = 0; req1_addr = AW'($urandom_range(0, 15));
        wait_rsp(base + 4, 30, "rr_timeout");
        req0_valid = 0; req1_valid = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_q.size() > base + k) chk("rr_dut_order", rsp_q[base + k].id, k % 2);
            if (mg_q.size() > na + k) chk("rr_model_order", mg_q[na + k], k % 2);
        end

        // Response backpressure on requester 0, requester 1 waiting.
        rsp0_ready = 0;
        req0_valid = 1; req0_we = 0; req0_addr = 10'h005;
        na = acc_q.size();
        wait_acc(na + 1, 5, "bp_acc_timeout");
        req0_valid = 0;
        req1_valid = 1; req1_we = 0; req1_addr = 10'h010;
        for (int k = 0; k < 6 && !rsp0_valid; k++) step();
        chk("bp_rsp0_valid_rise", rsp0_valid, 1);
        repeat (5) begin
            step();
            chk("bp_valid_hold", rsp0_valid, 1);
            chk("bp_rdata_hold", rsp0_rdata, 32'hDEADBEEF);
            chk("bp_busy", busy, 1);
            chk("bp_req1_blocked", req1_ready, 0);
        end
        rsp0_ready = 1;
        step();
        chk("bp_req1_ready_next_idle", req1_ready, 1);
        wait_acc(na + 2, 5, "bp_acc1_timeout");
        req1_valid = 0;
        repeat (6) step();

        // Asynchronous reset during WAIT.
        req0_valid = 1; req0_we = 0; req0_addr = 10'h005;
        na = acc_q.size();
        wait_acc(na + 1, 5, "mid_acc_timeout");
        req0_valid = 0;
        step();
        rst_n = 0;
        #1;
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        req0_valid = 1; req1_valid = 1; req1_we = 0; req1_addr = 10'h003;
        base = rsp_q.size();
        repeat (2) step();
        rst_n = 1;
        #1;
        chk("post_rst_req0_ready", req0_ready, 1);
        chk("post_rst_req1_ready", req1_ready, 0);
        na = acc_q.size();
        wait_acc(na + 1, 3, "post_rst_acc_timeout");
        if (acc_q.size() > na) chk("post_rst_first_grant", acc_q[na].id, 0);
        req0_valid = 0;
        wait_acc(na + 2, 10, "post_rst_acc1_timeout");
        req1_valid = 0;
        repeat (6) step();
        chk("mid_rst_rsp_count", rsp_q.size() - base, 2);

        // Randomized traffic.
        repeat (800) begin
            req0_valid = ($urandom_range(0, 99) < 55);
            req0_we    = $urandom_range(0, 1);
            req0_addr  = AW'($urandom_range(0, 15));
            req0_wdata = $urandom;
            req0_be    = BW'($urandom);
            req1_valid = ($urandom_range(0, 99) < 55);
            req1_we    = $urandom_range(0, 1);
            req1_addr  = AW'($urandom_range(0, 15));
            req1_wdata = $urandom;
            req1_be    = BW'($urandom);
            rsp0_ready = ($urandom_range(0, 99) < 75);
            rsp1_ready = ($urandom_range(0, 99) < 75);
            step();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (8) step();
        chk("drain_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
